// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module      : y86_pkg
// Description : Shared Y86-64 constants and the E-register control struct.
// Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

    localparam logic [3:0] IHALT    = 4'h0;
    localparam logic [3:0] INOP     = 4'h1;
    localparam logic [3:0] IRRMOVQ  = 4'h2;
    localparam logic [3:0] IIRMOVQ  = 4'h3;
    localparam logic [3:0] IRMMOVQ  = 4'h4;
    localparam logic [3:0] IMRMOVQ  = 4'h5;
    localparam logic [3:0] IOPQ     = 4'h6;
    localparam logic [3:0] IJXX     = 4'h7;
    localparam logic [3:0] ICALL    = 4'h8;
    localparam logic [3:0] IRET     = 4'h9;
    localparam logic [3:0] IPUSHQ   = 4'hA;
    localparam logic [3:0] IPOPQ    = 4'hB;

    localparam logic [3:0] RNONE    = 4'hF;
    localparam logic [3:0] STAT_BUB = 4'h8;

    typedef struct packed {
        logic [3:0] stat;
        logic [3:0] icode;
        logic [3:0] ifun;
        logic [3:0] srcA;
        logic [3:0] srcB;
        logic [3:0] dstE;
        logic [3:0] dstM;
    } e_ctl_t;

    localparam e_ctl_t E_CTL_BUBBLE = '{
        stat:  STAT_BUB,
        icode: INOP,
        ifun:  4'h0,
        srcA:  RNONE,
        srcB:  RNONE,
        dstE:  RNONE,
        dstM:  RNONE
    };

endpackage
`default_nettype wire

// File: rtl/y86_regfile.sv
`default_nettype none
// ============================================================================
// Module      : y86_regfile
// Description : NREGS x XLEN register file, 2 read / 2 write / 1 debug port.
// Revision    : 1.0 - initial release
// ============================================================================
module y86_regfile
    import y86_pkg::*;
#(
    parameter int         XLEN     = 64,
    parameter int         NREGS    = 15,
    parameter logic [3:0] RSP_ID   = 4'd4,
    parameter int         RSP_INIT = 28
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      rd_a_id_i,
    output logic [XLEN-1:0] rd_a_data_o,
    input  logic [3:0]      rd_b_id_i,
    output logic [XLEN-1:0] rd_b_data_o,
    input  logic [3:0]      wr_e_id_i,
    input  logic [XLEN-1:0] wr_e_data_i,
    input  logic [3:0]      wr_m_id_i,
    input  logic [XLEN-1:0] wr_m_data_i,
    input  logic [3:0]      dbg_id_i,
    output logic [XLEN-1:0] dbg_data_o
);

    logic [XLEN-1:0] regs_q [NREGS];

    function automatic logic valid_id(input logic [3:0] id);
        return (id != RNONE) && (int'(id) < NREGS);
    endfunction

    assign rd_a_data_o = valid_id(rd_a_id_i) ? regs_q[rd_a_id_i] : '0;
    assign rd_b_data_o = valid_id(rd_b_id_i) ? regs_q[rd_b_id_i] : '0;
    assign dbg_data_o  = valid_id(dbg_id_i)  ? regs_q[dbg_id_i]  : '0;

    // M write is issued last so it wins on equal IDs (popq %rsp).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == int'(RSP_ID)) ? XLEN'(RSP_INIT) : '0;
            end
        end else begin
            if (valid_id(wr_e_id_i)) regs_q[wr_e_id_i] <= wr_e_data_i;
            if (valid_id(wr_m_id_i)) regs_q[wr_m_id_i] <= wr_m_data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/decode_regfile_fwd.sv
`default_nettype none
// ============================================================================
// Module      : decode_regfile_fwd
// Description : Y86-64 decode stage with register file, forwarding, load/use
//               detection and the D->E pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_regfile_fwd
    import y86_pkg::*;
#(
    parameter int         XLEN     = 64,
    parameter int         NREGS    = 15,
    parameter logic [3:0] RSP_ID   = 4'd4,
    parameter int         RSP_INIT = 28
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      D_stat,
    input  logic [3:0]      D_icode,
    input  logic [3:0]      D_ifun,
    input  logic [3:0]      D_rA,
    input  logic [3:0]      D_rB,
    input  logic [XLEN-1:0] D_valC,
    input  logic [XLEN-1:0] D_valP,
    input  logic            E_stall,
    input  logic            E_bubble,
    input  logic [3:0]      e_dstE,
    input  logic [XLEN-1:0] e_valE,
    input  logic [3:0]      M_dstE,
    input  logic [XLEN-1:0] M_valE,
    input  logic [3:0]      M_dstM,
    input  logic [XLEN-1:0] m_valM,
    input  logic [3:0]      W_dstE,
    input  logic [XLEN-1:0] W_valE,
    input  logic [3:0]      W_dstM,
    input  logic [XLEN-1:0] W_valM,
    output logic [3:0]      d_srcA,
    output logic [3:0]      d_srcB,
    output logic            d_loaduse,
    output logic [3:0]      E_stat,
    output logic [3:0]      E_icode,
    output logic [3:0]      E_ifun,
    output logic [3:0]      E_srcA,
    output logic [3:0]      E_srcB,
    output logic [3:0]      E_dstE,
    output logic [3:0]      E_dstM,
    output logic [XLEN-1:0] E_valA,
    output logic [XLEN-1:0] E_valB,
    output logic [XLEN-1:0] E_valC,
    input  logic [3:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    e_ctl_t          e_ctl_d, e_ctl_q;
    logic [XLEN-1:0] valA_d, valB_d;
    logic [XLEN-1:0] valA_q, valB_q, valC_q;
    logic [XLEN-1:0] rf_a, rf_b;

    always_comb begin
        e_ctl_d       = E_CTL_BUBBLE;
        e_ctl_d.stat  = D_stat;
        e_ctl_d.icode = D_icode;
        e_ctl_d.ifun  = D_ifun;
        case (D_icode)
            IRRMOVQ: begin e_ctl_d.srcA = D_rA; e_ctl_d.dstE = D_rB; end
            IIRMOVQ: begin e_ctl_d.dstE = D_rB; end
            IRMMOVQ: begin e_ctl_d.srcA = D_rA; e_ctl_d.srcB = D_rB; end
            IMRMOVQ: begin e_ctl_d.srcB = D_rB; e_ctl_d.dstM = D_rA; end
            IOPQ: begin
                e_ctl_d.srcA = D_rA; e_ctl_d.srcB = D_rB; e_ctl_d.dstE = D_rB;
            end
            ICALL: begin e_ctl_d.srcB = RSP_ID; e_ctl_d.dstE = RSP_ID; end
            IRET: begin
                e_ctl_d.srcA = RSP_ID; e_ctl_d.srcB = RSP_ID; e_ctl_d.dstE = RSP_ID;
            end
            IPUSHQ: begin
                e_ctl_d.srcA = D_rA; e_ctl_d.srcB = RSP_ID; e_ctl_d.dstE = RSP_ID;
            end
            IPOPQ: begin
                e_ctl_d.srcA = RSP_ID; e_ctl_d.srcB = RSP_ID;
                e_ctl_d.dstE = RSP_ID; e_ctl_d.dstM = D_rA;
            end
            default: ;
        endcase
    end

    assign d_srcA = e_ctl_d.srcA;
    assign d_srcB = e_ctl_d.srcB;

    y86_regfile #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .RSP_ID   (RSP_ID),
        .RSP_INIT (RSP_INIT)
    ) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .rd_a_id_i   (d_srcA),
        .rd_a_data_o (rf_a),
        .rd_b_id_i   (d_srcB),
        .rd_b_data_o (rf_b),
        .wr_e_id_i   (W_dstE),
        .wr_e_data_i (W_valE),
        .wr_m_id_i   (W_dstM),
        .wr_m_data_i (W_valM),
        .dbg_id_i    (dbg_addr),
        .dbg_data_o  (dbg_data)
    );

    // Youngest producer first; RNONE never matches a destination.
    always_comb begin
        valA_d = rf_a;
        if (D_icode == IJXX || D_icode == ICALL) valA_d = D_valP;
        else if (d_srcA != RNONE && d_srcA == e_dstE) valA_d = e_valE;
        else if (d_srcA != RNONE && d_srcA == M_dstM) valA_d = m_valM;
        else if (d_srcA != RNONE && d_srcA == M_dstE) valA_d = M_valE;
        else if (d_srcA != RNONE && d_srcA == W_dstM) valA_d = W_valM;
        else if (d_srcA != RNONE && d_srcA == W_dstE) valA_d = W_valE;
    end

    always_comb begin
        valB_d = rf_b;
        if (d_srcB != RNONE && d_srcB == e_dstE) valB_d = e_valE;
        else if (d_srcB != RNONE && d_srcB == M_dstM) valB_d = m_valM;
        else if (d_srcB != RNONE && d_srcB == M_dstE) valB_d = M_valE;
        else if (d_srcB != RNONE && d_srcB == W_dstM) valB_d = W_valM;
        else if (d_srcB != RNONE && d_srcB == W_dstE) valB_d = W_valE;
    end

    assign d_loaduse = (e_ctl_q.icode == IMRMOVQ || e_ctl_q.icode == IPOPQ)
                     && (e_ctl_q.dstM != RNONE)
                     && (e_ctl_q.dstM == d_srcA || e_ctl_q.dstM == d_srcB);

    always_ff @(posedge clk) begin
        if (rst || E_bubble) begin
            e_ctl_q <= E_CTL_BUBBLE;
            valA_q  <= '0;
            valB_q  <= '0;
            valC_q  <= '0;
        end else if (!E_stall) begin
            e_ctl_q <= e_ctl_d;
            valA_q  <= valA_d;
            valB_q  <= valB_d;
            valC_q  <= D_valC;
        end
    end

    assign E_stat  = e_ctl_q.stat;
    assign E_icode = e_ctl_q.icode;
    assign E_ifun  = e_ctl_q.ifun;
    assign E_srcA  = e_ctl_q.srcA;
    assign E_srcB  = e_ctl_q.srcB;
    assign E_dstE  = e_ctl_q.dstE;
    assign E_dstM  = e_ctl_q.dstM;
    assign E_valA  = valA_q;
    assign E_valB  = valB_q;
    assign E_valC  = valC_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_regfile_fwd.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_regfile_fwd
// Description : Directed self-checking bench for decode_regfile_fwd.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_regfile_fwd;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  D_stat, D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic        E_stall, E_bubble;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [3:0]  d_srcA, d_srcB;
    logic        d_loaduse;
    logic [3:0]  E_stat, E_icode, E_ifun, E_srcA, E_srcB, E_dstE, E_dstM;
    logic [63:0] E_valA, E_valB, E_valC;
    logic [3:0]  dbg_addr;
    logic [63:0] dbg_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decode_regfile_fwd dut (
        .clk(clk), .rst(rst),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP),
        .E_stall(E_stall), .E_bubble(E_bubble),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstE(M_dstE), .M_valE(M_valE), .M_dstM(M_dstM), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_loaduse(d_loaduse),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_srcA(E_srcA),
        .E_srcB(E_srcB), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_d(input logic [3:0] icode, input logic [3:0] ra, input logic [3:0] rb);
        D_icode = icode;
        D_rA    = ra;
        D_rB    = rb;
    endtask

    task automatic clear_fwd();
        e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
    endtask

    initial begin
        rst = 1'b1; E_stall = 1'b0; E_bubble = 1'b0;
        D_stat = 4'h1; D_ifun = 4'h0; D_valC = '0; D_valP = '0;
        set_d(4'h1, 4'hF, 4'hF);
        clear_fwd();
        e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
        dbg_addr = 4'd4;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        #1;
        chk("rst_rsp", dbg_data, 64'd28);
        dbg_addr = 4'd0; #1;
        chk("rst_r0", dbg_data, 64'd0);
        chk("rst_icode", {60'd0, E_icode}, 64'd1);
        chk("rst_stat", {60'd0, E_stat}, 64'd8);
        chk("rst_dstE", {60'd0, E_dstE}, 64'hF);

        // Forwarding priority: e beats M on srcA, W feeds srcB
        set_d(4'h6, 4'd2, 4'd3);
        e_dstE = 4'd2; e_valE = 64'd5;
        M_dstE = 4'd2; M_valE = 64'd9;
        W_dstE = 4'd3; W_valE = 64'd7;
        #1;
        chk("opq_srcA", {60'd0, d_srcA}, 64'd2);
        chk("opq_srcB", {60'd0, d_srcB}, 64'd3);
        tick();
        chk("fwd_valA", E_valA, 64'd5);
        chk("fwd_valB", E_valB, 64'd7);
        chk("opq_icode", {60'd0, E_icode}, 64'd6);
        chk("opq_dstE", {60'd0, E_dstE}, 64'd3);
        chk("opq_stat", {60'd0, E_stat}, 64'd1);
        clear_fwd();
        dbg_addr = 4'd3; #1;
        chk("wb_r3", dbg_data, 64'd7);

        // M_dstM beats M_dstE; unforwarded srcA reads regfile
        M_dstM = 4'd3; m_valM = 64'd11;
        M_dstE = 4'd3; M_valE = 64'd12;
        tick();
        chk("mm_valA", E_valA, 64'd0);
        chk("mm_valB", E_valB, 64'd11);
        clear_fwd();

        // Load/use
        set_d(4'h5, 4'd2, 4'd3);
        tick();
        chk("mr_icode", {60'd0, E_icode}, 64'd5);
        chk("mr_dstM", {60'd0, E_dstM}, 64'd2);
        chk("mr_dstE", {60'd0, E_dstE}, 64'hF);
        chk("mr_valB", E_valB, 64'd7);
        set_d(4'h6, 4'd2, 4'd3); #1;
        chk("lu_srcA", {63'd0, d_loaduse}, 64'd1);
        set_d(4'h6, 4'd5, 4'd2); #1;
        chk("lu_srcB", {63'd0, d_loaduse}, 64'd1);
        set_d(4'h5, 4'hF, 4'd3);
        tick();
        set_d(4'h6, 4'd2, 4'd3); #1;
        chk("lu_none", {63'd0, d_loaduse}, 64'd0);

        // Write-back: M port wins on equal IDs, R14 lands, RNONE is dropped
        set_d(4'h1, 4'hF, 4'hF);
        W_dstE = 4'd4; W_valE = 64'd20; W_dstM = 4'd4; W_valM = 64'd99;
        tick();
        clear_fwd();
        dbg_addr = 4'd4; #1;
        chk("wb_mwins", dbg_data, 64'd99);
        W_dstE = 4'd14; W_valE = 64'h1234;
        tick();
        W_dstE = 4'hF; W_valE = 64'h55;
        dbg_addr = 4'd14; #1;
        chk("wb_r14", dbg_data, 64'h1234);
        tick();
        dbg_addr = 4'd4; #1;
        chk("wb_none", dbg_data, 64'd99);
        dbg_addr = 4'd15; #1;
        chk("dbg_oor", dbg_data, 64'd0);

        // Stall holds, bubble overrides stall
        set_d(4'h3, 4'hF, 4'd5); D_valC = 64'h77;
        tick();
        chk("ir_icode", {60'd0, E_icode}, 64'd3);
        chk("ir_dstE", {60'd0, E_dstE}, 64'd5);
        set_d(4'h6, 4'd1, 4'd2); D_valC = 64'h88; E_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_icode", {60'd0, E_icode}, 64'd3);
            chk("stall_valC", E_valC, 64'h77);
        end
        E_bubble = 1'b1;
        tick();
        chk("bub_icode", {60'd0, E_icode}, 64'd1);
        chk("bub_stat", {60'd0, E_stat}, 64'd8);
        chk("bub_valC", E_valC, 64'd0);
        chk("bub_dstE", {60'd0, E_dstE}, 64'hF);
        E_stall = 1'b0; E_bubble = 1'b0;

        // call uses valP for valA and %rsp for srcB/dstE
        set_d(4'h8, 4'hF, 4'hF); D_valP = 64'h40; D_valC = 64'h100;
        tick();
        chk("call_valA", E_valA, 64'h40);
        chk("call_srcA", {60'd0, E_srcA}, 64'hF);
        chk("call_srcB", {60'd0, E_srcB}, 64'd4);
        chk("call_dstE", {60'd0, E_dstE}, 64'd4);
        chk("call_valB", E_valB, 64'd99);
        chk("call_valC", E_valC, 64'h100);

        // Reset mid-stream; the W write in the reset cycle is ignored
        rst = 1'b1; W_dstE = 4'd4; W_valE = 64'hAA;
        tick();
        rst = 1'b0; W_dstE = 4'hF;
        dbg_addr = 4'd4; #1;
        chk("rst2_icode", {60'd0, E_icode}, 64'd1);
        chk("rst2_rsp", dbg_data, 64'd28);
        dbg_addr = 4'd14; #1;
        chk("rst2_r14", dbg_data, 64'd0);
        dbg_addr = 4'd3; #1;
        chk("rst2_r3", dbg_data, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
